// File: rtl/full_seven_segment_display.sv
// -----------------------------------------------------------------------------
// full_seven_segment_display
//
// Drives a 4-digit, common-anode, multiplexed seven-segment display from an
// 8-bit two's-complement value. The number is shown in decimal with
// leading-zero blanking. A minus sign appears in the leftmost digit for
// negative values.
//
// A free-running refresh counter scans the digits. Its top two bits pick the
// active digit. Anode and cathode drives are registered, so they lag the
// counter and the value input by one clock.
//
// Ports
//   clk_100MHz  in   1  system clock; all logic on the rising edge
//   rst_n       in   1  synchronous reset, active-low
//   value       in   8  signed number to display, -128..127
//   anodes      out  4  digit enables, active-low; bit 0 = ones, bit 3 = sign
//   cathodes    out  8  segment drives, active-low, {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module full_seven_segment_display #(
    parameter int REFRESH_BITS = 20
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [7:0] value,
    output logic [3:0] anodes,
    output logic [7:0] cathodes
);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low segment pattern for one decimal digit; dp stays off.
    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Tens digit of a remainder in 0..99, found by threshold compares so no
    // divider is inferred.
    function automatic logic [3:0] tens_of(input logic [6:0] r);
        logic [3:0] t;
        t = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (r >= 7'(10 * i)) t = 4'(i);
        end
        return t;
    endfunction

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;

    logic signed [7:0] value_s;
    logic signed [8:0] value_ext;
    logic signed [8:0] mag_s;
    logic        [8:0] mag;
    logic              is_neg;
    logic              hundreds;
    logic        [8:0] rem_full;
    logic        [6:0] rem;
    logic        [3:0] tens;
    logic        [6:0] ones_full;
    logic        [3:0] ones;

    logic [3:0] anodes_nxt;
    logic [7:0] cathodes_nxt;

    assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

    // Magnitude is computed at 9 bits so that -128 maps to +128 without
    // overflowing.
    assign value_s   = value;
    assign value_ext = {value_s[7], value_s};
    assign is_neg    = value_ext[8];
    assign mag_s     = is_neg ? -value_ext : value_ext;
    assign mag       = $unsigned(mag_s);

    // The magnitude never exceeds 128, so the hundreds digit is 0 or 1.
    assign hundreds  = (mag >= 9'd100);
    assign rem_full  = hundreds ? (mag - 9'd100) : mag;
    assign rem       = rem_full[6:0];
    assign tens      = tens_of(rem);
    assign ones_full = rem - (7'(tens) * 7'd10);
    assign ones      = ones_full[3:0];

    always_comb begin
        anodes_nxt   = 4'b1111;
        cathodes_nxt = SEG_BLANK;
        case (sel)
            2'd0: begin
                anodes_nxt   = 4'b1110;
                cathodes_nxt = seg_digit(ones);
            end
            2'd1: begin
                anodes_nxt   = 4'b1101;
                cathodes_nxt = (mag >= 9'd10) ? seg_digit(tens) : SEG_BLANK;
            end
            2'd2: begin
                anodes_nxt   = 4'b1011;
                cathodes_nxt = hundreds ? seg_digit(4'(hundreds)) : SEG_BLANK;
            end
            default: begin
                anodes_nxt   = 4'b0111;
                cathodes_nxt = is_neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    // Output register stage: drives reflect the counter and value sampled
    // on the previous edge.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            anodes      <= 4'b1111;
            cathodes    <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            anodes      <= anodes_nxt;
            cathodes    <= cathodes_nxt;
        end
    end

endmodule

// File: tb/tb_full_seven_segment_display.sv
// -----------------------------------------------------------------------------
// tb_full_seven_segment_display
//
// Directed bench for full_seven_segment_display with a short refresh counter
// (REFRESH_BITS = 4, each digit held 4 cycles, full scan 16 cycles).
// It covers reset, the scan order after release, hand-computed digit patterns,
// an all-values sweep against a divide/modulo reference, and reset mid-scan.
// -----------------------------------------------------------------------------
module tb_full_seven_segment_display;

    localparam int RB = 4;

    logic       clk_100MHz;
    logic       rst_n;
    logic [7:0] value;
    logic [3:0] anodes;
    logic [7:0] cathodes;

    int checks   = 0;
    int failures = 0;

    full_seven_segment_display #(.REFRESH_BITS(RB)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .value      (value),
        .anodes     (anodes),
        .cathodes   (cathodes)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_digit(input int d);
        logic [7:0] s;
        case (d)
            0: s = 8'hC0; 1: s = 8'hF9; 2: s = 8'hA4; 3: s = 8'hB0; 4: s = 8'h99;
            5: s = 8'h92; 6: s = 8'h82; 7: s = 8'hF8; 8: s = 8'h80; 9: s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Reference pattern for digit position pos (0 = ones .. 3 = sign).
    function automatic logic [7:0] ref_seg(input logic [7:0] v, input int pos);
        int sv;
        int mag;
        logic [7:0] s;
        sv  = int'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        case (pos)
            0:       s = ref_digit(mag % 10);
            1:       s = (mag >= 10)  ? ref_digit((mag / 10) % 10) : 8'hFF;
            2:       s = (mag >= 100) ? ref_digit(mag / 100) : 8'hFF;
            default: s = (sv < 0) ? 8'hBF : 8'hFF;
        endcase
        return s;
    endfunction

    // Apply v, then watch one full scan and check each digit drawn.
    task automatic scan(input string tag, input logic [7:0] v,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        logic [3:0] seen;
        logic       onehot;
        logic [7:0] exp_c;
        seen  = 4'b0000;
        value = v;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_100MHz);
            onehot = 1'b1;
            exp_c  = 8'hxx;
            case (anodes)
                4'b1110: begin exp_c = e0; seen[0] = 1'b1; end
                4'b1101: begin exp_c = e1; seen[1] = 1'b1; end
                4'b1011: begin exp_c = e2; seen[2] = 1'b1; end
                4'b0111: begin exp_c = e3; seen[3] = 1'b1; end
                default: onehot = 1'b0;
            endcase
            chk({tag, "_onehot"}, 32'(onehot), 32'd1);
            chk({tag, "_dp"}, 32'(cathodes[7]), 32'd1);
            if (onehot) chk({tag, "_seg"}, 32'(cathodes), 32'(exp_c));
        end
        chk({tag, "_all_digits"}, 32'(seen), 32'hF);
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [7:0] exp_ca [4];
        logic       found;
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_ca = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};

        // Reset for two edges with value = 0.
        rst_n = 1'b0;
        value = 8'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_100MHz);
            chk("reset_anodes", 32'(anodes), 32'hF);
            chk("reset_cathodes", 32'(cathodes), 32'hFF);
        end

        // Release: scan order ones, tens, hundreds, sign, 4 cycles each.
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_100MHz);
            chk("scan_anodes", 32'(anodes), 32'(exp_an[k / 4]));
            chk("scan_cathodes", 32'(cathodes), 32'(exp_ca[k / 4]));
        end

        // Hand-computed vectors (ones, tens, hundreds, sign).
        scan("v4",    8'd4,   8'h99, 8'hFF, 8'hFF, 8'hFF);
        scan("v9",    8'd9,   8'h90, 8'hFF, 8'hFF, 8'hFF);
        scan("v10",   8'd10,  8'hC0, 8'hF9, 8'hFF, 8'hFF);
        scan("v43",   8'd43,  8'hB0, 8'h99, 8'hFF, 8'hFF);
        scan("v99",   8'd99,  8'h90, 8'h90, 8'hFF, 8'hFF);
        scan("v100",  8'd100, 8'hC0, 8'hC0, 8'hF9, 8'hFF);
        scan("v114",  8'd114, 8'h99, 8'hF9, 8'hF9, 8'hFF);
        scan("v127",  8'd127, 8'hF8, 8'hA4, 8'hF9, 8'hFF);
        scan("vm1",   8'hFF,  8'hF9, 8'hFF, 8'hFF, 8'hBF);
        scan("vm127", 8'h81,  8'hF8, 8'hA4, 8'hF9, 8'hBF);
        scan("vm128", 8'h80,  8'h80, 8'hA4, 8'hF9, 8'hBF);

        // Every input value against the reference model.
        for (int v = 0; v < 256; v++) begin
            scan("sweep", 8'(v), ref_seg(8'(v), 0), ref_seg(8'(v), 1),
                 ref_seg(8'(v), 2), ref_seg(8'(v), 3));
        end

        // Reset while the hundreds digit is being drawn.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk_100MHz);
            if (anodes == 4'b1011) found = 1'b1;
        end
        chk("mid_reset_sync", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk_100MHz);
        chk("mid_reset_anodes", 32'(anodes), 32'hF);
        chk("mid_reset_cathodes", 32'(cathodes), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk_100MHz);
        chk("restart_anodes", 32'(anodes), 32'hE);
        chk("restart_cathodes", 32'(cathodes), 32'(ref_seg(value, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
